sram_axi_bridge: RTL and testbench
==================================

# sram_axi_bridge

Converts the core's two SRAM-like ports (instruction, data; req/addr_ok/data_ok protocol) into a single 32-bit AXI master. It sits between the pipeline top and the system bus and supports up to `RD_DEPTH` outstanding reads per port. Reads are tagged by AXI ID. Data-port reads and writes are serialised so that data-port `data_ok` order always matches request order.

## Interface
- `RD_DEPTH`, 2: maximum outstanding reads per port, 1..8; counter width is clog2(RD_DEPTH+1).
- `INST_ID`, 4'd0: ARID used for instruction reads.
- `DATA_ID`, 4'd1: ARID/AWID used for data accesses; must differ from `INST_ID`.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `inst_sram_req/wr/size/addr/wstrb/wdata` in 1/1/2/32/4/32: instruction request. `wr`, `wstrb` and `wdata` are ignored.
- `inst_sram_addr_ok` out 1: instruction request accepted this cycle.
- `inst_sram_data_ok` out 1: instruction read data valid this cycle.
- `inst_sram_rdata` out 32: instruction read data.
- `data_sram_req/wr/size/addr/wstrb/wdata` in 1/1/2/32/4/32: data request.
- `data_sram_addr_ok` out 1: data request accepted. `data_sram_data_ok` out 1: read data or write completion. `data_sram_rdata` out 32: data read data.
- `arid/araddr/arsize` out 4/32/3: read address. `arvalid` out 1. `arready` in 1.
- `arlen`=0, `arburst`=2'b01, `arlock`=0, `arcache`=0, `arprot`=0: tied constants, out.
- `rid/rdata/rresp/rlast` in 4/32/2/1. `rvalid` in 1. `rready` out 1, tied to 1.
- `awid/awaddr/awsize` out 4/32/3. `awvalid` out 1. `awready` in 1. `awlen`/`awburst`/`awlock`/`awcache`/`awprot`: same constants as AR.
- `wid/wdata/wstrb/wlast` out 4/32/4/1; `wlast`=1. `wvalid` out 1. `wready` in 1.
- `bid/bresp` in 4/2. `bvalid` in 1. `bready` out 1, tied to 1.

## Operation
- **AR slot:** a single register holds {id, addr, size}. It is free when `arvalid`=0, or when `arvalid & arready` (back-to-back issue).
- **Read counters:** `icnt` and `dcnt` count outstanding reads per port.
  - +1 on read `addr_ok`; −1 on an R handshake whose `rid` matches the port's ID.
  - If both happen in the same cycle, the count is unchanged.
- **Write state:** `wpend` is set on write `addr_ok` and cleared on a B handshake.
- **Data read accept:** `data_req & ~data_wr & AR-slot free & dcnt<RD_DEPTH & ~wpend`.
- **Data write accept:** `data_req & data_wr & ~wpend & dcnt==0`, and no data-ID AR pending in the slot.
  - On accept, load `awvalid` and `wvalid` together. `size` maps to `awsize` as {0,size}.
- **Inst read accept:** `inst_req & AR-slot free & icnt<RD_DEPTH`, and no data read accepted in the same cycle. Data reads have AR priority.
- **AW/W channels:** each valid drops independently on its own ready. `wpend` stays 1 until B.
- **R routing:** `rid==INST_ID` drives `inst_data_ok=1` and `inst_rdata=rdata`. `rid==DATA_ID` drives `data_data_ok=1` and `data_rdata=rdata`.
- **B routing:** `bvalid` drives `data_data_ok=1`. It can never coincide with a data R response, because reads and writes are exclusive.
- **Response handling:** `rresp` and `bresp` are ignored. An R with an unknown ID is dropped (`rready`=1) and changes no counter.
- **Reset:** `arvalid`, `awvalid`, `wvalid`, `wpend`, `icnt`, `dcnt` all go to 0. All `addr_ok`/`data_ok` outputs are 0 during reset. In-flight AXI transactions are abandoned.

## Timing
- `addr_ok` is combinational from `req` and state, in the same cycle.
- `arvalid` / `awvalid` / `wvalid` assert in the cycle after `addr_ok`.
- `data_ok` and `rdata` are combinational from `rvalid` / `bvalid`.
- Minimum read latency: `req` in cycle 0, `arvalid` in cycle 1; with `arready` in cycle 1 and `rvalid` in cycle 2, `data_ok` occurs in cycle 2.
- Per-ID in-order R return is required of the slave; the bridge performs no reordering.
- `araddr` and the other AR fields are held stable while `arvalid & ~arready`. The same rule applies to AW and W.

## Test plan
- **Single inst read:** `inst_req` at 0x1C000000 with `arready`=1 → `addr_ok` in cycle 0, `arvalid`/`araddr`=0x1C000000/`arid`=0 in cycle 1; R with `rid`=0, `rdata`=0x02800C0C → `inst_data_ok`=1, `inst_rdata`=0x02800C0C.
- **Inst depth limit (RD_DEPTH=2):** three back-to-back inst reqs with R withheld → 2 `addr_ok`, third stalls. One R returns → third accepted the same cycle.
- **Simultaneous requests:** inst and data reads in the same cycle → only `data_addr_ok`; the first AR carries `arid`=1 and the inst read issues next.
- **Data write then read:** write 0x8 with `wstrb`=4'b0011, `wdata`=0x12345678; read to 0x8 requested while `wpend` → read `addr_ok`=0 until B; B → `data_data_ok`=1, then read accepted the next cycle.
- **Split AW/W ready:** `awready`=1 in cycle 1 and `wready`=1 in cycle 3 → `awvalid` drops in cycle 2, `wvalid` is held through cycle 3; no second write is accepted before `bvalid`.
- **Reset mid-operation:** reset with `icnt`=2 and `arvalid`=1 → all valids and counters 0 the cycle after; a new inst req after reset deasserts is accepted immediately.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one 32-bit AXI master.
// Reads are tagged per port by ARID; data-port reads and writes are mutually exclusive.
module sram_axi_bridge #(
    parameter int unsigned RD_DEPTH = 2,
    parameter logic [3:0]  INST_ID  = 4'd0,
    parameter logic [3:0]  DATA_ID  = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    // instruction port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    // data port
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int unsigned    CW    = $clog2(RD_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH = CW'(RD_DEPTH);

    logic          ar_valid_q;
    logic [3:0]    ar_id_q;
    logic [31:0]   ar_addr_q;
    logic [2:0]    ar_size_q;
    logic [CW-1:0] icnt_q, icnt_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          wpend_q;
    logic          aw_valid_q;
    logic          w_valid_q;
    logic [31:0]   aw_addr_q;
    logic [2:0]    aw_size_q;
    logic [31:0]   w_data_q;
    logic [3:0]    w_strb_q;

    logic ar_free, r_inst, r_data, i_ret, d_ret, i_room, d_room;
    logic data_rd_acc, data_wr_acc, inst_rd_acc;

    // A read returning this cycle frees its slot, so a stalled request can take it at once.
    always_comb begin
        ar_free     = ~ar_valid_q | arready;
        r_inst      = rvalid & (rid == INST_ID);
        r_data      = rvalid & (rid == DATA_ID);
        i_ret       = r_inst & (icnt_q != '0);
        d_ret       = r_data & (dcnt_q != '0);
        i_room      = (icnt_q < DEPTH) | i_ret;
        d_room      = (dcnt_q < DEPTH) | d_ret;
        data_rd_acc = ~reset & data_sram_req & ~data_sram_wr & ar_free & d_room & ~wpend_q;
        data_wr_acc = ~reset & data_sram_req & data_sram_wr & ~wpend_q & (dcnt_q == '0)
                    & ~(ar_valid_q & (ar_id_q == DATA_ID));
        inst_rd_acc = ~reset & inst_sram_req & ar_free & i_room & ~data_rd_acc;

        icnt_d = icnt_q;
        if (inst_rd_acc && !i_ret) begin
            icnt_d = icnt_q + CW'(1);
        end else if (!inst_rd_acc && i_ret) begin
            icnt_d = icnt_q - CW'(1);
        end

        dcnt_d = dcnt_q;
        if (data_rd_acc && !d_ret) begin
            dcnt_d = dcnt_q + CW'(1);
        end else if (!data_rd_acc && d_ret) begin
            dcnt_d = dcnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_valid_q <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_size_q  <= '0;
            icnt_q     <= '0;
            dcnt_q     <= '0;
            wpend_q    <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_addr_q  <= '0;
            aw_size_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            icnt_q <= icnt_d;
            dcnt_q <= dcnt_d;

            if (ar_free) begin
                ar_valid_q <= data_rd_acc | inst_rd_acc;
                if (data_rd_acc) begin
                    ar_id_q   <= DATA_ID;
                    ar_addr_q <= data_sram_addr;
                    ar_size_q <= {1'b0, data_sram_size};
                end else if (inst_rd_acc) begin
                    ar_id_q   <= INST_ID;
                    ar_addr_q <= inst_sram_addr;
                    ar_size_q <= {1'b0, inst_sram_size};
                end
            end

            if (data_wr_acc) begin
                wpend_q    <= 1'b1;
                aw_valid_q <= 1'b1;
                w_valid_q  <= 1'b1;
                aw_addr_q  <= data_sram_addr;
                aw_size_q  <= {1'b0, data_sram_size};
                w_data_q   <= data_sram_wdata;
                w_strb_q   <= data_sram_wstrb;
            end else begin
                if (awready) aw_valid_q <= 1'b0;
                if (wready)  w_valid_q  <= 1'b0;
                if (bvalid)  wpend_q    <= 1'b0;
            end
        end
    end

    assign inst_sram_addr_ok = inst_rd_acc;
    assign data_sram_addr_ok = data_rd_acc | data_wr_acc;
    assign inst_sram_data_ok = ~reset & r_inst;
    assign data_sram_data_ok = ~reset & (r_data | bvalid);
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arsize  = ar_size_q;
    assign arvalid = ar_valid_q;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign rready  = 1'b1;

    assign awid    = DATA_ID;
    assign awaddr  = aw_addr_q;
    assign awsize  = aw_size_q;
    assign awvalid = aw_valid_q;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid    = DATA_ID;
    assign wdata  = w_data_q;
    assign wstrb  = w_strb_q;
    assign wlast  = 1'b1;
    assign wvalid = w_valid_q;
    assign bready = 1'b1;

    // Inputs the bridge deliberately ignores.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast,
                             bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: directed cycle table for the corner cases, then random traffic
// against a queue-based model of both ports and a simple AXI slave.
module tb_sram_axi_bridge;

    localparam int         D   = 2;
    localparam logic [3:0] IID = 4'd0;
    localparam logic [3:0] DID = 4'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic [3:0]  inst_sram_wstrb;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    sram_axi_bridge #(.RD_DEPTH(D), .INST_ID(IID), .DATA_ID(DID)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic idle();
        reset = 1'b0;
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
        inst_sram_addr = '0; inst_sram_wstrb = '0; inst_sram_wdata = '0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
        data_sram_addr = '0; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h1234_5678;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = DID; bresp = '0; bvalid = 1'b0;
    endtask

    // One table row = inputs for one cycle plus the outputs expected in that cycle.
    typedef struct {
        logic        rst, ireq;
        logic [31:0] iaddr;
        logic        dreq, dwr;
        logic [31:0] daddr;
        logic        arr, rv;
        logic [3:0]  rid;
        logic [31:0] rdat;
        logic        awr, wr, bv;
        logic        eia, eda, eid, edd, earv;
        logic [3:0]  earid;
        logic [31:0] earaddr;
        logic        eaw, ew;
    } vec_t;

    function automatic vec_t mk(
        input int rst, input int ireq, input logic [31:0] iaddr,
        input int dreq, input int dwr, input logic [31:0] daddr,
        input int arr, input int rv, input int rid_v, input logic [31:0] rdat,
        input int awr, input int wr, input int bv,
        input int eia, input int eda, input int eid, input int edd,
        input int earv, input int earid, input logic [31:0] earaddr,
        input int eaw, input int ew);
        vec_t v;
        v.rst = (rst != 0);   v.ireq = (ireq != 0); v.iaddr = iaddr;
        v.dreq = (dreq != 0); v.dwr = (dwr != 0);   v.daddr = daddr;
        v.arr = (arr != 0);   v.rv = (rv != 0);     v.rid = 4'(rid_v); v.rdat = rdat;
        v.awr = (awr != 0);   v.wr = (wr != 0);     v.bv = (bv != 0);
        v.eia = (eia != 0);   v.eda = (eda != 0);   v.eid = (eid != 0); v.edd = (edd != 0);
        v.earv = (earv != 0); v.earid = 4'(earid); v.earaddr = earaddr;
        v.eaw = (eaw != 0);   v.ew = (ew != 0);
        return v;
    endfunction

    vec_t vec[$];

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
    } ar_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
    } dreq_t;

    initial begin
        idle();
        reset = 1'b1;
        // rst ireq iaddr | dreq dwr daddr | arr rv rid rdat | awr wr bv |
        //   eia eda eid edd | earv earid earaddr | eaw ew
        vec.push_back(mk(1,1,32'h1C00_0000, 0,0,0, 1,0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0));
        // single inst read
        vec.push_back(mk(0,1,32'h1C00_0000, 0,0,0, 1,0,0,0, 0,0,0, 1,0,0,0, 0,0,0, 0,0));
        vec.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0,0,0, 0,0,0,0, 1,0,32'h1C00_0000, 0,0));
        vec.push_back(mk(0,0,0, 0,0,0, 0,1,0,32'h0280_0C0C, 0,0,0, 0,0,1,0, 0,0,0, 0,0));
        // inst depth limit; the returning R frees room for the stalled third request
        vec.push_back(mk(0,1,32'h100, 0,0,0, 1,0,0,0, 0,0,0, 1,0,0,0, 0,0,0, 0,0));
        vec.push_back(mk(0,1,32'h104, 0,0,0, 1,0,0,0, 0,0,0, 1,0,0,0, 1,0,32'h100, 0,0));
        vec.push_back(mk(0,1,32'h108, 0,0,0, 1,0,0,0, 0,0,0, 0,0,0,0, 1,0,32'h104, 0,0));
        vec.push_back(mk(0,1,32'h108, 0,0,0, 1,0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0));
        vec.push_back(mk(0,1,32'h108, 0,0,0, 1,1,0,32'h1111_1111, 0,0,0, 1,0,1,0, 0,0,0, 0,0));
        vec.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0,0,0, 0,0,0,0, 1,0,32'h108, 0,0));
        vec.push_back(mk(0,0,0, 0,0,0, 0,1,0,32'h2222_2222, 0,0,0, 0,0,1,0, 0,0,0, 0,0));
        vec.push_back(mk(0,0,0, 0,0,0, 0,1,0,32'h3333_3333, 0,0,0, 0,0,1,0, 0,0,0, 0,0));
        // simultaneous inst and data reads: data wins the AR slot
        vec.push_back(mk(0,1,32'h200, 1,0,32'h300, 0,0,0,0, 0,0,0, 0,1,0,0, 0,0,0, 0,0));
        vec.push_back(mk(0,1,32'h200, 0,0,0, 1,0,0,0, 0,0,0, 1,0,0,0, 1,1,32'h300, 0,0));
        vec.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0,0,0, 0,0,0,0, 1,0,32'h200, 0,0));
        vec.push_back(mk(0,0,0, 0,0,0, 0,1,1,32'h4444_4444, 0,0,0, 0,0,0,1, 0,0,0, 0,0));
        vec.push_back(mk(0,0,0, 0,0,0, 0,1,0,32'h5555_5555, 0,0,0, 0,0,1,0, 0,0,0, 0,0));
        // write, split AW/W ready, read held off until B
        vec.push_back(mk(0,0,0, 1,1,32'h8, 0,0,0,0, 0,0,0, 0,1,0,0, 0,0,0, 0,0));
        vec.push_back(mk(0,0,0, 1,0,32'h8, 0,0,0,0, 1,0,0, 0,0,0,0, 0,0,0, 1,1));
        vec.push_back(mk(0,0,0, 1,0,32'h8, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,1));
        vec.push_back(mk(0,0,0, 1,0,32'h8, 0,0,0,0, 0,1,0, 0,0,0,0, 0,0,0, 0,1));
        vec.push_back(mk(0,0,0, 1,1,32'hC, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0));
        vec.push_back(mk(0,0,0, 1,0,32'h8, 0,0,0,0, 0,0,1, 0,0,0,1, 0,0,0, 0,0));
        vec.push_back(mk(0,0,0, 1,0,32'h8, 0,0,0,0, 0,0,0, 0,1,0,0, 0,0,0, 0,0));
        vec.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0,0,0, 0,0,0,0, 1,1,32'h8, 0,0));
        vec.push_back(mk(0,0,0, 0,0,0, 0,1,1,32'h6666_6666, 0,0,0, 0,0,0,1, 0,0,0, 0,0));
        // unknown-ID R is dropped silently
        vec.push_back(mk(0,0,0, 0,0,0, 0,1,7,32'h7777_7777, 0,0,0, 0,0,0,0, 0,0,0, 0,0));
        // reset with icnt=2 and arvalid=1
        vec.push_back(mk(0,1,32'h400, 0,0,0, 0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0, 0,0));
        vec.push_back(mk(0,1,32'h404, 0,0,0, 1,0,0,0, 0,0,0, 1,0,0,0, 1,0,32'h400, 0,0));
        vec.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 1,0,32'h404, 0,0));
        vec.push_back(mk(1,1,32'h500, 0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 1,0,32'h404, 0,0));
        vec.push_back(mk(0,1,32'h500, 0,0,0, 0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0, 0,0));
        vec.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0,0,0, 0,0,0,0, 1,0,32'h500, 0,0));

        for (int k = 0; k < vec.size(); k++) begin
            @(posedge clk);
            #1;
            reset = vec[k].rst;
            inst_sram_req = vec[k].ireq;  inst_sram_addr = vec[k].iaddr;
            data_sram_req = vec[k].dreq;  data_sram_wr = vec[k].dwr;
            data_sram_addr = vec[k].daddr;
            arready = vec[k].arr; rvalid = vec[k].rv; rid = vec[k].rid; rdata = vec[k].rdat;
            awready = vec[k].awr; wready = vec[k].wr; bvalid = vec[k].bv;
            #1;
            check1("tbl inst_addr_ok", inst_sram_addr_ok, vec[k].eia);
            check1("tbl data_addr_ok", data_sram_addr_ok, vec[k].eda);
            check1("tbl inst_data_ok", inst_sram_data_ok, vec[k].eid);
            check1("tbl data_data_ok", data_sram_data_ok, vec[k].edd);
            check1("tbl arvalid", arvalid, vec[k].earv);
            check1("tbl awvalid", awvalid, vec[k].eaw);
            check1("tbl wvalid", wvalid, vec[k].ew);
            if (vec[k].earv) begin
                check32("tbl arid", 32'(arid), 32'(vec[k].earid));
                check32("tbl araddr", araddr, vec[k].earaddr);
            end
            if (vec[k].eid) check32("tbl inst_rdata", inst_sram_rdata, vec[k].rdat);
            if (vec[k].edd && vec[k].rv) check32("tbl data_rdata", data_sram_rdata, vec[k].rdat);
            if (vec[k].eaw) check32("tbl awaddr", awaddr, 32'h8);
            if (vec[k].ew) begin
                check32("tbl wdata", wdata, 32'h1234_5678);
                check32("tbl wstrb", 32'(wstrb), 32'h3);
            end
        end
        check1("tie rready", rready, 1'b1);
        check1("tie bready", bready, 1'b1);
        check1("tie wlast", wlast, 1'b1);
        check32("tie arburst", 32'(arburst), 32'h1);
        check32("tie awlen", 32'(awlen), 32'h0);

        // Random traffic against a request-level model.
        begin
            logic [31:0] inst_q[$];
            dreq_t       data_q[$];
            ar_t         ar_pend[$];
            logic [31:0] slv_i[$], slv_d[$];
            ar_t         a;
            int          dr_out;
            bit          wpend_m, aw_pend, w_pend, b_due;
            logic [31:0] wr_addr, wr_data;
            logic [3:0]  wr_strb;
            logic [2:0]  wr_size;
            logic        ir, dr, slot_free, e_drd, e_dwr, e_ird;
            int          r;

            dr_out = 0; wpend_m = 0; aw_pend = 0; w_pend = 0; b_due = 0;
            wr_addr = '0; wr_data = '0; wr_strb = '0; wr_size = '0;
            @(posedge clk); #1;
            idle();
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;

            for (int cyc = 0; cyc < 4000; cyc++) begin
                @(posedge clk);
                #1;
                arready = ($urandom_range(0, 3) != 0);
                awready = ($urandom_range(0, 2) != 0);
                wready  = ($urandom_range(0, 2) != 0);
                rvalid = 1'b0; rid = '0; rdata = $urandom; bvalid = 1'b0;
                r = int'($urandom_range(0, 9));
                if (r < 3 && slv_i.size() > 0) begin
                    rvalid = 1'b1; rid = IID; rdata = mem(slv_i[0]);
                end else if (r < 6 && slv_d.size() > 0) begin
                    rvalid = 1'b1; rid = DID; rdata = mem(slv_d[0]);
                end else if (r == 6) begin
                    rvalid = 1'b1; rid = 4'd9;
                end
                if (b_due && $urandom_range(0, 2) == 0) bvalid = 1'b1;

                inst_sram_req  = ($urandom_range(0, 1) != 0);
                inst_sram_addr = $urandom & 32'hFFFF_FFFC;
                data_sram_req  = ($urandom_range(0, 1) != 0);
                data_sram_wr   = ($urandom_range(0, 2) == 0);
                data_sram_addr = $urandom & 32'hFFFF_FFFC;
                data_sram_size = 2'($urandom_range(0, 2));
                data_sram_wdata = $urandom;
                data_sram_wstrb = 4'($urandom);
                #1;

                ir = rvalid && (rid == IID);
                dr = rvalid && (rid == DID);
                slot_free = (ar_pend.size() == 0) || arready;
                e_drd = data_sram_req && !data_sram_wr && slot_free
                        && (dr_out - int'(dr)) < D && !wpend_m;
                e_dwr = data_sram_req && data_sram_wr && !wpend_m && dr_out == 0;
                e_ird = inst_sram_req && slot_free
                        && (inst_q.size() - int'(ir)) < D && !e_drd;

                check1("rnd inst_addr_ok", inst_sram_addr_ok, e_ird);
                check1("rnd data_addr_ok", data_sram_addr_ok, e_drd | e_dwr);
                check1("rnd inst_data_ok", inst_sram_data_ok, ir);
                check1("rnd data_data_ok", data_sram_data_ok, dr | bvalid);
                if (ir) check32("rnd inst_rdata", inst_sram_rdata, mem(inst_q[0]));
                if (dr) begin
                    check1("rnd data order (read)", data_q[0].wr, 1'b0);
                    check32("rnd data_rdata", data_sram_rdata, mem(data_q[0].addr));
                end
                if (bvalid) check1("rnd data order (write)", data_q[0].wr, 1'b1);
                check1("rnd arvalid", arvalid, ar_pend.size() > 0);
                if (ar_pend.size() > 0) begin
                    check32("rnd arid", 32'(arid), 32'(ar_pend[0].id));
                    check32("rnd araddr", araddr, ar_pend[0].addr);
                    check32("rnd arsize", 32'(arsize), 32'(ar_pend[0].size));
                end
                check1("rnd awvalid", awvalid, aw_pend);
                check1("rnd wvalid", wvalid, w_pend);
                if (aw_pend) begin
                    check32("rnd awaddr", awaddr, wr_addr);
                    check32("rnd awsize", 32'(awsize), 32'(wr_size));
                end
                if (w_pend) begin
                    check32("rnd wdata", wdata, wr_data);
                    check32("rnd wstrb", 32'(wstrb), 32'(wr_strb));
                end

                if (ir) begin
                    void'(inst_q.pop_front());
                    void'(slv_i.pop_front());
                end
                if (dr) begin
                    void'(data_q.pop_front());
                    void'(slv_d.pop_front());
                    dr_out--;
                end
                if (bvalid) begin
                    void'(data_q.pop_front());
                    wpend_m = 0;
                    b_due = 0;
                end
                if (ar_pend.size() > 0 && arready) begin
                    a = ar_pend.pop_front();
                    if (a.id == IID) slv_i.push_back(a.addr);
                    else slv_d.push_back(a.addr);
                end
                if (aw_pend && awready) aw_pend = 0;
                if (w_pend && wready) w_pend = 0;
                if (wpend_m && !aw_pend && !w_pend) b_due = 1;

                if (e_drd) begin
                    ar_pend.push_back('{id: DID, addr: data_sram_addr,
                                        size: {1'b0, data_sram_size}});
                    data_q.push_back('{wr: 1'b0, addr: data_sram_addr});
                    dr_out++;
                end else if (e_ird) begin
                    ar_pend.push_back('{id: IID, addr: inst_sram_addr,
                                        size: {1'b0, inst_sram_size}});
                    inst_q.push_back(inst_sram_addr);
                end
                if (e_dwr) begin
                    wpend_m = 1; aw_pend = 1; w_pend = 1;
                    wr_addr = data_sram_addr; wr_data = data_sram_wdata;
                    wr_strb = data_sram_wstrb; wr_size = {1'b0, data_sram_size};
                    data_q.push_back('{wr: 1'b1, addr: data_sram_addr});
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
